// File: rtl/rect_fill_engine.sv
// rect_fill_engine: clips one rectangle command to the framebuffer and emits
// one pixel write per clock in raster order on the framebuffer write port.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for a command; Cmd_Ready high
// CLIP   | one cycle: clip latched rectangle, detect empty, load cursor
// DRAW   | one pixel write per cycle, raster order, abortable
// FINISH | one cycle: Done pulse, then back to IDLE
module rect_fill_engine #(
  parameter int FB_WIDTH   = 160,
  parameter int FB_HEIGHT  = 120,
  parameter int COLOR_BITS = 9
) (
  input  logic        Fast_Clock,
  input  logic        Reset_N,
  input  logic        Cmd_Valid,
  output logic        Cmd_Ready,
  input  logic [31:0] Cmd_X,
  input  logic [31:0] Cmd_Y,
  input  logic [31:0] Cmd_W,
  input  logic [31:0] Cmd_H,
  input  logic [31:0] Cmd_Color,
  input  logic        Cmd_Abort,
  output logic        Enable_Draw,
  output logic [31:0] Draw_X,
  output logic [31:0] Draw_Y,
  output logic [31:0] Draw_Color,
  output logic        Busy,
  output logic        Done
);

  typedef enum logic [1:0] {S_IDLE, S_CLIP, S_DRAW, S_FINISH} state_t;

  state_t                r_state;
  logic [31:0]           r_org_x;
  logic [31:0]           r_org_y;
  logic [31:0]           r_wid;
  logic [31:0]           r_hgt;
  logic [COLOR_BITS-1:0] r_color;
  logic [31:0]           r_x_last;
  logic [31:0]           r_y_last;
  logic                  r_en;
  logic [31:0]           r_draw_x;
  logic [31:0]           r_draw_y;
  logic [COLOR_BITS-1:0] r_draw_color;
  logic                  r_busy;
  logic                  r_done;

  logic [32:0] w_x_sum;
  logic [32:0] w_y_sum;
  logic [31:0] w_x_last;
  logic [31:0] w_y_last;
  logic        w_empty;
  logic        w_row_end;
  logic        w_last_pixel;
  logic        w_unused_color;

  // Clip against the framebuffer with 33-bit sums so X+W can never wrap;
  // the last drawable coordinate is stored rather than the exclusive end.
  always_comb begin
    w_x_sum      = {1'b0, r_org_x} + {1'b0, r_wid};
    w_y_sum      = {1'b0, r_org_y} + {1'b0, r_hgt};
    w_x_last     = (w_x_sum >= 33'(FB_WIDTH))  ? 32'(FB_WIDTH - 1)
                                               : (w_x_sum[31:0] - 32'd1);
    w_y_last     = (w_y_sum >= 33'(FB_HEIGHT)) ? 32'(FB_HEIGHT - 1)
                                               : (w_y_sum[31:0] - 32'd1);
    w_empty      = (r_org_x >= 32'(FB_WIDTH)) || (r_org_y >= 32'(FB_HEIGHT)) ||
                   (r_wid == 32'd0) || (r_hgt == 32'd0);
    w_row_end    = (r_draw_x == r_x_last);
    w_last_pixel = w_row_end && (r_draw_y == r_y_last);
  end

  // Only the low colour bits are significant; the rest are dropped here.
  assign w_unused_color = &{1'b0, Cmd_Color[31:COLOR_BITS]};

  assign Cmd_Ready   = (r_state == S_IDLE) && Reset_N;
  assign Enable_Draw = r_en;
  assign Draw_X      = r_draw_x;
  assign Draw_Y      = r_draw_y;
  assign Draw_Color  = {{(32 - COLOR_BITS){1'b0}}, r_draw_color};
  assign Busy        = r_busy;
  assign Done        = r_done;

  // Command FSM with registered draw port; the draw registers double as the cursor.
  always_ff @(posedge Fast_Clock or negedge Reset_N) begin
    if (!Reset_N) begin
      r_state      <= S_IDLE;
      r_org_x      <= '0;
      r_org_y      <= '0;
      r_wid        <= '0;
      r_hgt        <= '0;
      r_color      <= '0;
      r_x_last     <= '0;
      r_y_last     <= '0;
      r_en         <= 1'b0;
      r_draw_x     <= '0;
      r_draw_y     <= '0;
      r_draw_color <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (Cmd_Valid) begin
            r_org_x <= Cmd_X;
            r_org_y <= Cmd_Y;
            r_wid   <= Cmd_W;
            r_hgt   <= Cmd_H;
            r_color <= Cmd_Color[COLOR_BITS-1:0];
            r_busy  <= 1'b1;
            r_state <= S_CLIP;
          end
        end
        S_CLIP: begin
          if (w_empty) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_FINISH;
          end else begin
            r_x_last     <= w_x_last;
            r_y_last     <= w_y_last;
            r_draw_x     <= r_org_x;
            r_draw_y     <= r_org_y;
            r_draw_color <= r_color;
            r_en         <= 1'b1;
            r_state      <= S_DRAW;
          end
        end
        S_DRAW: begin
          // An abort still lets the pixel currently presented be written.
          if (Cmd_Abort || w_last_pixel) begin
            r_en    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_FINISH;
          end else if (w_row_end) begin
            r_draw_x <= r_org_x;
            r_draw_y <= r_draw_y + 32'd1;
          end else begin
            r_draw_x <= r_draw_x + 32'd1;
          end
        end
        S_FINISH: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
